// File: rtl/reservation_station_if.sv
// Rob/ALU-facing bus of the ALU reservation station: instruction insert, the two
// wakeup broadcasts, stall back-pressure and the issue port.
interface reservation_station_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned OpWidth   = 6
);
   logic                 is_empty_from_rob;
   logic                 is_exception_from_rob;
   logic [DataWidth-1:0] pc_from_rob;
   logic [OpWidth-1:0]   op_from_rob;
   logic [DataWidth-1:0] v1_from_rob;
   logic [DataWidth-1:0] v2_from_rob;
   logic [DataWidth-1:0] q1_from_rob;
   logic [DataWidth-1:0] q2_from_rob;
   logic [DataWidth-1:0] imm_from_rob;
   logic                 is_finish_from_alu;
   logic [DataWidth-1:0] pc_from_alu;
   logic [DataWidth-1:0] data_from_alu;
   logic                 is_commit_from_rob;
   logic [DataWidth-1:0] commit_pc_from_rob;
   logic [DataWidth-1:0] commit_data_from_rob;
   logic                 is_stall_to_rob;
   logic                 is_empty_to_alu;
   logic [OpWidth-1:0]   op_to_alu;
   logic [DataWidth-1:0] v1_to_alu;
   logic [DataWidth-1:0] v2_to_alu;
   logic [DataWidth-1:0] imm_to_alu;
   logic [DataWidth-1:0] pc_to_alu;

   modport slave (
      input  is_empty_from_rob, is_exception_from_rob, pc_from_rob, op_from_rob,
             v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob,
             is_finish_from_alu, pc_from_alu, data_from_alu,
             is_commit_from_rob, commit_pc_from_rob, commit_data_from_rob,
      output is_stall_to_rob, is_empty_to_alu, op_to_alu, v1_to_alu, v2_to_alu,
             imm_to_alu, pc_to_alu
   );

   modport master (
      output is_empty_from_rob, is_exception_from_rob, pc_from_rob, op_from_rob,
             v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob,
             is_finish_from_alu, pc_from_alu, data_from_alu,
             is_commit_from_rob, commit_pc_from_rob, commit_data_from_rob,
      input  is_stall_to_rob, is_empty_to_alu, op_to_alu, v1_to_alu, v2_to_alu,
             imm_to_alu, pc_to_alu
   );
endinterface

// File: rtl/reservation_station.sv
// Out-of-order ALU reservation station: holds renamed instructions until both
// operands are available, wakes them from ALU/commit broadcasts, issues one per cycle.
module reservation_station #(
   parameter int unsigned RsSize    = 8,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned OpWidth   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   reservation_station_if.slave bus_io
);
   localparam int unsigned IdxW = $clog2(RsSize);
   localparam int unsigned CntW = IdxW + 1;

   typedef logic [DataWidth-1:0] word_t;

   logic [RsSize-1:0]  valid_q, valid_d;
   logic [OpWidth-1:0] op_q  [RsSize];
   logic [OpWidth-1:0] op_d  [RsSize];
   word_t              pc_q  [RsSize];
   word_t              pc_d  [RsSize];
   word_t              imm_q [RsSize];
   word_t              imm_d [RsSize];
   word_t              v1_q  [RsSize];
   word_t              v1_d  [RsSize];
   word_t              v2_q  [RsSize];
   word_t              v2_d  [RsSize];
   word_t              q1_q  [RsSize];
   word_t              q1_d  [RsSize];
   word_t              q2_q  [RsSize];
   word_t              q2_d  [RsSize];

   logic               overflow_q, overflow_d;
   logic               stall_q, stall_d;
   logic               empty_q;
   logic [OpWidth-1:0] op_out_q;
   word_t              pc_out_q, imm_out_q, v1_out_q, v2_out_q;

   logic [IdxW-1:0]    free_idx, issue_idx;
   logic               full, issue_vld, flush, insert;
   logic [CntW-1:0]    occ_d;

   logic               alu_vld, cm_vld;
   word_t              alu_tag, alu_data, cm_tag, cm_data;

   assign alu_vld  = bus_io.is_finish_from_alu;
   assign alu_tag  = bus_io.pc_from_alu;
   assign alu_data = bus_io.data_from_alu;
   assign cm_vld   = bus_io.is_commit_from_rob;
   assign cm_tag   = bus_io.commit_pc_from_rob;
   assign cm_data  = bus_io.commit_data_from_rob;

   assign flush  = bus_io.is_exception_from_rob;
   assign insert = !bus_io.is_empty_from_rob && !flush;

   // Tag 0 means "already ready", so it never matches a broadcast.
   function automatic logic tag_hit(input word_t q);
      return (q != '0) && ((alu_vld && q == alu_tag) || (cm_vld && q == cm_tag));
   endfunction

   function automatic word_t wake_v(input word_t q, input word_t v);
      if (q != '0 && alu_vld && q == alu_tag) return alu_data;
      if (q != '0 && cm_vld && q == cm_tag) return cm_data;
      return v;
   endfunction

   function automatic word_t wake_q(input word_t q);
      return tag_hit(q) ? '0 : q;
   endfunction

   always_comb begin
      free_idx  = '0;
      issue_idx = '0;
      full      = 1'b1;
      issue_vld = 1'b0;
      for (int i = RsSize - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = IdxW'(i);
            full     = 1'b0;
         end
         if (valid_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
            issue_idx = IdxW'(i);
            issue_vld = 1'b1;
         end
      end
   end

   always_comb begin
      valid_d    = valid_q;
      op_d       = op_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      overflow_d = overflow_q;
      for (int i = 0; i < RsSize; i++) begin
         v1_d[i] = wake_v(q1_q[i], v1_q[i]);
         q1_d[i] = wake_q(q1_q[i]);
         v2_d[i] = wake_v(q2_q[i], v2_q[i]);
         q2_d[i] = wake_q(q2_q[i]);
      end
      if (issue_vld) valid_d[issue_idx] = 1'b0;
      // Free slot is chosen from registered state, so an issuing slot is not reused this edge.
      if (insert) begin
         if (full) begin
            overflow_d = 1'b1;
         end else begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = bus_io.op_from_rob;
            pc_d[free_idx]    = bus_io.pc_from_rob;
            imm_d[free_idx]   = bus_io.imm_from_rob;
            v1_d[free_idx]    = wake_v(bus_io.q1_from_rob, bus_io.v1_from_rob);
            q1_d[free_idx]    = wake_q(bus_io.q1_from_rob);
            v2_d[free_idx]    = wake_v(bus_io.q2_from_rob, bus_io.v2_from_rob);
            q2_d[free_idx]    = wake_q(bus_io.q2_from_rob);
         end
      end
      if (flush) valid_d = '0;
      occ_d = '0;
      for (int i = 0; i < RsSize; i++) occ_d = occ_d + CntW'(valid_d[i]);
      // One slot of headroom for the instruction rob sends before it sees the stall.
      stall_d = (occ_d >= CntW'(RsSize - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= '0;
         overflow_q <= 1'b0;
         stall_q    <= 1'b0;
         empty_q    <= 1'b1;
         op_out_q   <= '0;
         pc_out_q   <= '0;
         imm_out_q  <= '0;
         v1_out_q   <= '0;
         v2_out_q   <= '0;
         for (int i = 0; i < RsSize; i++) begin
            op_q[i]  <= '0;
            pc_q[i]  <= '0;
            imm_q[i] <= '0;
            v1_q[i]  <= '0;
            v2_q[i]  <= '0;
            q1_q[i]  <= '0;
            q2_q[i]  <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         op_q       <= op_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         q1_q       <= q1_d;
         q2_q       <= q2_d;
         overflow_q <= overflow_d;
         stall_q    <= stall_d;
         if (issue_vld && !flush) begin
            empty_q   <= 1'b0;
            op_out_q  <= op_q[issue_idx];
            pc_out_q  <= pc_q[issue_idx];
            imm_out_q <= imm_q[issue_idx];
            v1_out_q  <= v1_q[issue_idx];
            v2_out_q  <= v2_q[issue_idx];
         end else begin
            empty_q <= 1'b1;
         end
      end
   end

   assign bus_io.is_stall_to_rob = stall_q;
   assign bus_io.is_empty_to_alu = empty_q;
   assign bus_io.op_to_alu       = op_out_q;
   assign bus_io.pc_to_alu       = pc_out_q;
   assign bus_io.imm_to_alu      = imm_out_q;
   assign bus_io.v1_to_alu       = v1_out_q;
   assign bus_io.v2_to_alu       = v2_out_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, all checked
// cycle by cycle against a slot-level behavioural model of the station.
module tb_reservation_station;
   localparam int unsigned RsSize = 8;
   localparam int unsigned Dw     = 32;
   localparam int unsigned Ow     = 6;

   typedef logic [Dw-1:0] word_t;
   typedef struct {
      bit            vld;
      logic [Ow-1:0] op;
      word_t         pc, imm, v1, v2, q1, q2;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ent_t          m [RsSize];
   bit            want_empty, want_stall, want_ovf;
   logic [Ow-1:0] want_op;
   word_t         want_pc, want_imm, want_v1, want_v2;
   bit            stall_cur, stall_dly;

   always #5 clk = ~clk;

   reservation_station_if #(.DataWidth(Dw), .OpWidth(Ow)) bus ();

   reservation_station #(
      .RsSize   (RsSize),
      .DataWidth(Dw),
      .OpWidth  (Ow)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus)
   );

   task automatic chk(input string tag, input word_t got, input word_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // A tag is produced this cycle if either broadcast carries it; ALU data takes priority.
   function automatic bit produced(input word_t q);
      return q != 0 && ((bus.is_finish_from_alu && q == bus.pc_from_alu) ||
                        (bus.is_commit_from_rob && q == bus.commit_pc_from_rob));
   endfunction

   function automatic word_t produced_val(input word_t q);
      if (bus.is_finish_from_alu && q == bus.pc_from_alu) return bus.data_from_alu;
      return bus.commit_data_from_rob;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RsSize; i++) m[i].vld = 0;
      want_empty = 1; want_stall = 0; want_ovf = 0;
      want_op = '0; want_pc = '0; want_imm = '0; want_v1 = '0; want_v2 = '0;
      stall_cur = 0; stall_dly = 0;
   endtask

   task automatic check_outputs();
      chk("empty_to_alu", 32'(bus.is_empty_to_alu), 32'(want_empty));
      chk("stall_to_rob", 32'(bus.is_stall_to_rob), 32'(want_stall));
      chk("overflow", 32'(dut.overflow_q), 32'(want_ovf));
      chk("op_to_alu", 32'(bus.op_to_alu), 32'(want_op));
      chk("pc_to_alu", bus.pc_to_alu, want_pc);
      chk("imm_to_alu", bus.imm_to_alu, want_imm);
      chk("v1_to_alu", bus.v1_to_alu, want_v1);
      chk("v2_to_alu", bus.v2_to_alu, want_v2);
   endtask

   task automatic idle();
      bus.is_empty_from_rob     = 1;
      bus.is_exception_from_rob = 0;
      bus.pc_from_rob  = '0; bus.op_from_rob = '0; bus.imm_from_rob = '0;
      bus.v1_from_rob  = '0; bus.v2_from_rob = '0;
      bus.q1_from_rob  = '0; bus.q2_from_rob = '0;
      bus.is_finish_from_alu = 0; bus.pc_from_alu = '0; bus.data_from_alu = '0;
      bus.is_commit_from_rob = 0; bus.commit_pc_from_rob = '0; bus.commit_data_from_rob = '0;
   endtask

   task automatic offer(input word_t pc, input logic [Ow-1:0] op, input word_t q1,
                        input word_t v1, input word_t q2, input word_t v2, input word_t imm);
      bus.is_empty_from_rob = 0;
      bus.pc_from_rob = pc; bus.op_from_rob = op; bus.imm_from_rob = imm;
      bus.q1_from_rob = q1; bus.v1_from_rob = v1;
      bus.q2_from_rob = q2; bus.v2_from_rob = v2;
   endtask

   task automatic alu(input word_t tag, input word_t data);
      bus.is_finish_from_alu = 1; bus.pc_from_alu = tag; bus.data_from_alu = data;
   endtask

   // Apply one clock edge to the model using the inputs currently driven, then compare.
   task automatic step();
      int r = -1;
      int f = -1;
      int n = 0;
      bit fl = bus.is_exception_from_rob;
      for (int i = 0; i < RsSize; i++) begin
         if (r < 0 && m[i].vld && m[i].q1 == 0 && m[i].q2 == 0) r = i;
         if (f < 0 && !m[i].vld) f = i;
      end
      if (!fl && r >= 0) begin
         want_empty = 0;
         want_op = m[r].op; want_pc = m[r].pc; want_imm = m[r].imm;
         want_v1 = m[r].v1; want_v2 = m[r].v2;
      end else begin
         want_empty = 1;
      end
      for (int i = 0; i < RsSize; i++) begin
         if (m[i].vld && produced(m[i].q1)) begin m[i].v1 = produced_val(m[i].q1); m[i].q1 = 0; end
         if (m[i].vld && produced(m[i].q2)) begin m[i].v2 = produced_val(m[i].q2); m[i].q2 = 0; end
      end
      if (r >= 0) m[r].vld = 0;
      if (!bus.is_empty_from_rob && !fl) begin
         if (f < 0) begin
            want_ovf = 1;
         end else begin
            m[f].vld = 1; m[f].op = bus.op_from_rob; m[f].pc = bus.pc_from_rob;
            m[f].imm = bus.imm_from_rob;
            m[f].q1 = produced(bus.q1_from_rob) ? 0 : bus.q1_from_rob;
            m[f].v1 = produced(bus.q1_from_rob) ? produced_val(bus.q1_from_rob) : bus.v1_from_rob;
            m[f].q2 = produced(bus.q2_from_rob) ? 0 : bus.q2_from_rob;
            m[f].v2 = produced(bus.q2_from_rob) ? produced_val(bus.q2_from_rob) : bus.v2_from_rob;
         end
      end
      if (fl) for (int i = 0; i < RsSize; i++) m[i].vld = 0;
      for (int i = 0; i < RsSize; i++) n += int'(m[i].vld);
      want_stall = (n >= RsSize - 1);
      @(posedge clk);
      #1;
      check_outputs();
      stall_dly = stall_cur;
      stall_cur = bus.is_stall_to_rob;
   endtask

   // Reset asserted between edges: outputs must clear before the next clock.
   task automatic mid_reset();
      #1 rst = 1'b1;
      #1 model_reset();
      check_outputs();
      #1 rst = 1'b0;
   endtask

   initial begin
      word_t tag_a, tag_c, dat;
      idle();
      model_reset();
      #12;
      check_outputs();
      rst = 1'b0;

      // Ready-on-insert latency and single-cycle issue.
      offer(32'h10, 6'd1, 0, 3, 0, 4, 0);
      step();
      idle(); step();
      chk("t1_empty", 32'(bus.is_empty_to_alu), 0);
      chk("t1_pc", bus.pc_to_alu, 32'h10);
      chk("t1_v1", bus.v1_to_alu, 3);
      step();
      chk("t1_one_cycle", 32'(bus.is_empty_to_alu), 1);

      // Wakeup one cycle after insert, then snoop in the insert cycle.
      offer(32'h20, 6'd2, 32'h10, 0, 0, 5, 1);
      step();
      idle(); alu(32'h10, 7); step();
      idle(); step();
      chk("t2_pc", bus.pc_to_alu, 32'h20);
      chk("t2_v1", bus.v1_to_alu, 7);
      offer(32'h30, 6'd3, 32'h10, 0, 0, 6, 2); alu(32'h10, 9);
      step();
      idle(); step();
      chk("t2_snoop_v1", bus.v1_to_alu, 9);
      step();

      // Ready entries in slots 0, 2, 5 issue in index order; new inserts fill freed slots.
      for (int i = 0; i < 6; i++) begin
         offer(32'h40 + i, 6'(i), (i == 0 || i == 2 || i == 5) ? 32'h300 : 32'h400,
               0, 0, i, 0);
         step();
      end
      idle(); alu(32'h300, 32'h33); step();
      for (int i = 0; i < 3; i++) begin
         idle(); offer(32'h50 + i, 6'd7, 32'h400, 0, 0, 0, 0);
         step();
         chk("t4_order", bus.pc_to_alu, (i == 0) ? 32'h40 : (i == 1) ? 32'h42 : 32'h45);
      end
      idle(); alu(32'h400, 32'h44); step();
      idle();
      for (int i = 0; i < 10; i++) step();

      // Eight dependent inserts back to back: stall after the seventh, no overflow.
      for (int i = 0; i < 8; i++) begin
         offer(32'h60 + i, 6'd4, 32'h100, 0, 0, 0, 0);
         step();
         if (i == 6) chk("t3_stall", 32'(bus.is_stall_to_rob), 1);
      end
      chk("t3_no_issue", 32'(bus.is_empty_to_alu), 1);
      offer(32'h70, 6'd5, 0, 1, 0, 1, 0); bus.is_exception_from_rob = 1; step();
      chk("t5_stall_clear", 32'(bus.is_stall_to_rob), 0);
      idle(); alu(32'h100, 1); step();
      idle(); step();
      chk("t5_nothing", 32'(bus.is_empty_to_alu), 1);

      // Flush with five entries, concurrent insert and a matching broadcast.
      for (int i = 0; i < 5; i++) begin
         idle(); offer(32'h80 + i, 6'd6, 32'h200, 0, 0, 0, 0); step();
      end
      offer(32'h90, 6'd6, 0, 0, 0, 0, 0); alu(32'h200, 5); bus.is_exception_from_rob = 1;
      step();
      idle(); alu(32'h200, 5); step();
      idle(); step();
      chk("t5_flush_empty", 32'(bus.is_empty_to_alu), 1);

      // Reset while issuing.
      for (int i = 0; i < 3; i++) begin
         offer(32'hA0 + i, 6'd9, 0, i, 0, i, i); step();
      end
      idle();
      chk("t6_active", 32'(bus.is_empty_to_alu), 0);
      mid_reset();

      // Random traffic; rob honours stall one cycle late.
      for (int c = 0; c < 3000; c++) begin
         idle();
         if (!stall_dly && $urandom_range(0, 3) != 0)
            offer($urandom_range(1, 32'hFFFF), 6'($urandom), ($urandom_range(0, 1) != 0) ? 0 :
                  $urandom_range(1, 12), $urandom, ($urandom_range(0, 1) != 0) ? 0 :
                  $urandom_range(1, 12), $urandom, $urandom);
         tag_a = $urandom_range(1, 12);
         dat   = $urandom;
         if ($urandom_range(0, 2) == 0) alu(tag_a, dat);
         if ($urandom_range(0, 3) == 0) begin
            tag_c = $urandom_range(1, 12);
            bus.is_commit_from_rob   = 1;
            bus.commit_pc_from_rob   = tag_c;
            bus.commit_data_from_rob = (bus.is_finish_from_alu && tag_c == tag_a) ? dat : $urandom;
         end
         if ($urandom_range(0, 49) == 0) bus.is_exception_from_rob = 1;
         step();
         if ($urandom_range(0, 499) == 0) mid_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order reservation station for ALU instructions, directly downstream of the reorder buffer (rob). It accepts one renamed instruction per cycle from rob, holds it until both source operands are available, and issues one ready instruction per cycle to the ALU. Wakeup comes from the ALU result broadcast and the rob commit broadcast. An exception from rob flushes all entries.

## Interface
Parameters:
- RsSize, 8, number of entries (power of two, ≥4)
- DataWidth, 32, width of data, pc and tag fields
- OpWidth, 6, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- is_empty_from_rob  in  1  high = no instruction offered this cycle
- is_exception_from_rob  in  1  flush request
- pc_from_rob  in  DataWidth  instruction pc; also its result tag
- op_from_rob  in  OpWidth  opcode
- v1_from_rob, v2_from_rob  in  DataWidth  operand values, meaningful when matching q is 0
- q1_from_rob, q2_from_rob  in  DataWidth  producer tags; 0 = operand ready (rob never issues tag 0)
- imm_from_rob  in  DataWidth  immediate
- is_finish_from_alu  in  1  ALU result valid
- pc_from_alu, data_from_alu  in  DataWidth  ALU result tag and value
- is_commit_from_rob  in  1  commit broadcast valid
- commit_pc_from_rob, commit_data_from_rob  in  DataWidth  committed tag and value
- is_stall_to_rob  out  1  do not offer next cycle
- is_empty_to_alu  out  1  high = no issue this cycle
- op_to_alu  out  OpWidth;  v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  DataWidth  issued instruction

## Operation
- Each entry holds valid, op, pc, imm, v1, v2, q1, q2.
- Insert: when is_empty_from_rob=0 and no flush, the instruction is written into the lowest-index free entry. If the station is already full, the instruction is dropped and an internal overflow flag is set for the bench; this cannot happen while rob honours stall.
- Insert snoop: if q1/q2 of the incoming instruction matches a broadcast valid in the same cycle (ALU or commit), the entry stores q=0 and takes the broadcast data.
- Wakeup: every valid entry compares q1 and q2 against pc_from_alu (when is_finish_from_alu=1) and against commit_pc_from_rob (when is_commit_from_rob=1). A match sets v to the data and q to 0. If both buses match the same tag, ALU data wins; the values are identical by construction.
- Ready: valid entry with q1=0 and q2=0, evaluated on registered state.
- Issue: each cycle, the lowest-index ready entry drives the registered ALU outputs and is freed. is_empty_to_alu=0 for that one cycle. With no ready entry, is_empty_to_alu=1 and the data outputs hold their last values.
- Simultaneous insert and issue in one cycle are both performed. A freed slot can be reused on the next edge, not the same edge.
- Stall: is_stall_to_rob is registered, and is high when occupancy after the current edge ≥ RsSize−1. This leaves one slot for an instruction already in flight.
- Flush: is_exception_from_rob=1 clears every valid bit at the edge, discards that cycle's insert, sets is_empty_to_alu=1 and is_stall_to_rob=0 on the next cycle.

## Timing
- Reset (asynchronous): all entries invalid; is_empty_to_alu=1; is_stall_to_rob=0; all data/op outputs 0; overflow flag 0.
- Latency, ready-on-insert: offered at edge N, issued on outputs after edge N+1 (earliest).
- Latency, wakeup: broadcast at edge N, entry issues after edge N+1 at the earliest.
- Issue throughput: 1 per cycle. Insert throughput: 1 per cycle until stall.
- Stall is seen by rob one cycle late; RsSize−1 threshold covers exactly that cycle.
- Reset mid-operation: everything is cleared at once, with no issue of partial state.
- Flush and broadcast in the same cycle: flush wins; no entry survives.

## Test plan
- Reset, then insert pc=0x10, op=ADD, q1=q2=0, v1=3, v2=4 -> after 2 edges is_empty_to_alu=0, pc_to_alu=0x10, v1=3, v2=4, for exactly one cycle.
- Insert pc=0x20 with q1=0x10; next cycle ALU broadcasts pc=0x10, data=7 -> pc 0x20 issues one cycle later with v1_to_alu=7. Repeat with the broadcast in the insert cycle to cover the insert snoop.
- Insert 8 dependent instructions back to back (q1=0x100, never produced) -> is_stall_to_rob rises after the 7th insert, all 8 held, overflow flag 0, no issue.
- Fill with entries, 3 of them ready in slots 0, 2, 5 -> issue order is slot 0, 2, 5 on consecutive cycles; simultaneous inserts land in freed low slots.
- Assert is_exception_from_rob with 5 entries valid and an insert offered -> next cycle is_empty_to_alu=1, stall=0; a later broadcast issues nothing.
- Assert rst mid-stream with outputs active -> outputs take their reset values immediately, before the next clk edge.
